// File: rtl/game_pkg.sv
// Shared types and constants for the game score counter slice.
// The optional high-score feature is enabled by GAME_SCORE_HIGH_SCORE_EN (see game_score_counter).
package game_pkg;

   localparam int SCORE_W           = 14;
   localparam int BCD_W             = 16;
   localparam int SCORE_MAX_DEFAULT = 9999;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      OVER  = 2'd3
   } state_e;

   // One BCD digit plus one: {carry_out, next_digit}.
   function automatic logic [4:0] digit_inc(input logic [3:0] d);
      return (d == 4'd9) ? 5'b1_0000 : {1'b0, d + 4'd1};
   endfunction

endpackage

// File: rtl/game_score_counter_if.sv
// Control and score bus between the game logic and the score counter.
interface game_score_if;
   import game_pkg::*;

   logic               start;
   logic               pause;
   logic               collision;
   logic [SCORE_W-1:0] game_score;
   logic [BCD_W-1:0]   score_bcd;
   logic               milestone;
   logic               running;
   logic [SCORE_W-1:0] high_score;

   modport master (
      output start, pause, collision,
      input  game_score, score_bcd, milestone, running, high_score
   );

   modport slave (
      input  start, pause, collision,
      output game_score, score_bcd, milestone, running, high_score
   );

endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD incrementer with synchronous clear, saturation at 9999
// and a carry-out-of-tens flag (score about to become a multiple of 100).
module bcd_counter4
   import game_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [BCD_W-1:0] bcd,
   output logic             tens_co
);

   logic [3:0][3:0] dig_q, dig_d;
   logic [4:0]      carry;

   always_comb begin
      logic [4:0] nxt;
      nxt      = '0;
      dig_d    = dig_q;
      carry    = '0;
      carry[0] = inc & ~clr & (dig_q != 16'h9999);
      for (int i = 0; i < 4; i++) begin
         nxt = digit_inc(dig_q[i]);
         if (carry[i]) dig_d[i] = nxt[3:0];
         carry[i+1] = carry[i] & nxt[4];
      end
      if (clr) dig_d = '0;
      tens_co = carry[2];
   end

   always_ff @(posedge clk) begin
      if (rst) dig_q <= '0;
      else     dig_q <= dig_d;
   end

   assign bcd = dig_q;

endmodule

// File: rtl/game_score_counter.sv
// Run/pause/over score FSM with binary + BCD score and milestone pulse.
// Define GAME_SCORE_HIGH_SCORE_EN to build the best-score register.
module game_score_counter
   import game_pkg::*;
#(
   parameter int TICK_DIV  = 2500000,
   parameter int SCORE_MAX = SCORE_MAX_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   game_score_if.slave  bus
);

   localparam int                 TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);

   state_e             state_q, state_d;
   logic [TICK_W-1:0]  tick_q, tick_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               running_q, running_d;
   logic               milestone_q, milestone_d;
   logic               bcd_clr, bcd_inc, tens_co, enter_over;
   logic [BCD_W-1:0]   bcd;

   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q;
      score_d    = score_q;
      bcd_clr    = 1'b0;
      bcd_inc    = 1'b0;
      enter_over = 1'b0;
      case (state_q)
         IDLE, OVER: begin
            if (bus.start) begin
               state_d = RUN;
               tick_d  = '0;
               score_d = '0;
               bcd_clr = 1'b1;
            end
         end
         RUN: begin
            // Collision wins over both pause and a coincident tick wrap.
            if (bus.collision) begin
               state_d    = OVER;
               enter_over = 1'b1;
            end else begin
               tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
               if ((tick_q == TICK_LAST) && (score_q != SCORE_TOP)) begin
                  score_d = score_q + 1'b1;
                  bcd_inc = 1'b1;
               end
               if (bus.pause) state_d = PAUSE;
            end
         end
         PAUSE: begin
            if (bus.collision) begin
               state_d    = OVER;
               enter_over = 1'b1;
            end else if (!bus.pause) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
      running_d   = (state_d == RUN);
      milestone_d = tens_co;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         tick_q      <= '0;
         score_q     <= '0;
         running_q   <= 1'b0;
         milestone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         score_q     <= score_d;
         running_q   <= running_d;
         milestone_q <= milestone_d;
      end
   end

   bcd_counter4 u_bcd (
      .clk     (clk),
      .rst     (rst),
      .clr     (bcd_clr),
      .inc     (bcd_inc),
      .bcd     (bcd),
      .tens_co (tens_co)
   );

`ifdef GAME_SCORE_HIGH_SCORE_EN
   logic [SCORE_W-1:0] high_q, high_d;

   // Score cannot move on the edge into OVER, so score_q is the final score.
   always_comb begin
      high_d = high_q;
      if (enter_over && (score_q > high_q)) high_d = score_q;
   end

   always_ff @(posedge clk) begin
      if (rst) high_q <= '0;
      else     high_q <= high_d;
   end

   assign bus.high_score = high_q;
`else
   assign bus.high_score = '0;
`endif

   assign bus.game_score = score_q;
   assign bus.score_bcd  = bcd;
   assign bus.milestone  = milestone_q;
   assign bus.running    = running_q;

endmodule

// File: tb/tb_game_score_counter.sv
// Self-checking bench for game_score_counter with TICK_DIV=4.
module tb_game_score_counter;
   import game_pkg::*;

`ifdef GAME_SCORE_HIGH_SCORE_EN
   localparam bit HS_EN = 1'b1;
`else
   localparam bit HS_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   game_score_if bus ();

   game_score_counter #(.TICK_DIV(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      string       name;
      int          cyc;
      logic        pause;
      logic [13:0] score;
      logic [15:0] bcd;
      logic        run;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;
   int ms_cnt = 0;
   logic [13:0] ms_prev = '0, ms_at = '0, prev_score = '0;

   vec_t vecs[9];
   vec_t exp_q[$];

   always @(negedge clk) begin
      if (bus.milestone) begin
         ms_cnt++;
         ms_prev = prev_score;
         ms_at   = bus.game_score;
      end
      prev_score = bus.game_score;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   function automatic vec_t mk(string n, int c, logic p, logic [13:0] s, logic [15:0] b, logic r);
      vec_t v;
      v.name = n; v.cyc = c; v.pause = p; v.score = s; v.bcd = b; v.run = r;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      cycles(1);
      bus.start = 1'b0;
   endtask

   task automatic collide();
      bus.collision = 1'b1;
      cycles(1);
      bus.collision = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_score"}, bus.game_score, 0);
      chk({tag, "_bcd"},   bus.score_bcd, 0);
      chk({tag, "_ms"},    bus.milestone, 0);
      chk({tag, "_run"},   bus.running, 0);
      chk({tag, "_high"},  bus.high_score, 0);
   endtask

   initial begin
      vec_t e;
      vecs[0] = mk("r40",     40, 1'b0, 14'd10,  16'h0010, 1'b1);
      vecs[1] = mk("r100",    60, 1'b0, 14'd25,  16'h0025, 1'b1);
      vecs[2] = mk("r400",   300, 1'b0, 14'd100, 16'h0100, 1'b1);
      vecs[3] = mk("r402",     2, 1'b0, 14'd100, 16'h0100, 1'b1);
      vecs[4] = mk("p_mid",   10, 1'b1, 14'd100, 16'h0100, 1'b0);
      vecs[5] = mk("p_end",   10, 1'b1, 14'd100, 16'h0100, 1'b0);
      vecs[6] = mk("p_rel",    1, 1'b0, 14'd100, 16'h0100, 1'b1);
      vecs[7] = mk("p_first",  1, 1'b0, 14'd101, 16'h0101, 1'b1);
      vecs[8] = mk("r_next",   4, 1'b0, 14'd102, 16'h0102, 1'b1);

      // Reset held with every control input asserted: reset must win.
      bus.start = 1'b1; bus.pause = 1'b1; bus.collision = 1'b1;
      cycles(3);
      chk_zero("rst");
      rst = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.collision = 1'b0;
      cycles(2);
      chk("idle_run", bus.running, 0);

      // Collision on the same edge as the tick wrap at score 57.
      pulse_start();
      chk("s1_run", bus.running, 1);
      cycles(231);
      chk("s57_score", bus.game_score, 57);
      collide();
      chk("c57_score", bus.game_score, 57);
      chk("c57_bcd",   bus.score_bcd, 16'h0057);
      chk("c57_run",   bus.running, 0);
      chk("c57_high",  bus.high_score, HS_EN ? 57 : 0);
      cycles(5);
      chk("over_hold", bus.game_score, 57);

      // New run from OVER clears score; table covers run, milestone and pause.
      pulse_start();
      chk("clr_score", bus.game_score, 0);
      chk("clr_bcd",   bus.score_bcd, 0);
      ms_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         bus.pause = vecs[i].pause;
         exp_q.push_back(vecs[i]);
         cycles(vecs[i].cyc);
         e = exp_q.pop_front();
         chk({e.name, "_score"}, bus.game_score, e.score);
         chk({e.name, "_bcd"},   bus.score_bcd, e.bcd);
         chk({e.name, "_run"},   bus.running, e.run);
      end
      bus.pause = 1'b0;
      chk("ms_count", ms_cnt, 1);
      chk("ms_prev",  ms_prev, 99);
      chk("ms_at",    ms_at, 100);
      collide();
      chk("c102_high", bus.high_score, HS_EN ? 102 : 0);

      // Two runs: best score kept; start during RUN ignored.
      rst = 1'b1; cycles(1); rst = 1'b0;
      chk("r2_high0", bus.high_score, 0);
      pulse_start();
      cycles(121);
      collide();
      chk("run1_score", bus.game_score, 30);
      chk("run1_high",  bus.high_score, HS_EN ? 30 : 0);
      pulse_start();
      cycles(40);
      pulse_start();
      cycles(41);
      chk("run2_ign_score", bus.game_score, 20);
      chk("run2_ign_run",   bus.running, 1);
      collide();
      chk("run2_score", bus.game_score, 20);
      chk("run2_high",  bus.high_score, HS_EN ? 30 : 0);

      // Reset in the middle of a run.
      pulse_start();
      cycles(169);
      chk("r42_score", bus.game_score, 42);
      rst = 1'b1;
      cycles(1);
      chk_zero("midrst");
      rst = 1'b0;

      // Long run to saturation.
      pulse_start();
      ms_cnt = 0;
      cycles(39992);
      chk("s9998_score", bus.game_score, 9998);
      chk("s9998_bcd",   bus.score_bcd, 16'h9998);
      chk("s9998_ms",    ms_cnt, 99);
      cycles(12);
      chk("sat_score", bus.game_score, 9999);
      chk("sat_bcd",   bus.score_bcd, 16'h9999);
      chk("sat_ms",    ms_cnt, 99);
      chk("sat_run",   bus.running, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
